// File: rtl/mul_div_unit_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// The issuing stage uses the master modport; the unit uses the slave modport.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, mdu_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, mdu_op, in_a, in_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up in a dedicated cycle, result held until the consumer takes it.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    mul_div_unit_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0]   ONE_X   = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X  = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(XLEN - 1);

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              a_neg_q;
    logic [XLEN-1:0]   mag_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // Accept-time decode of signedness, magnitudes and special cases
    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    always_comb begin
        is_div      = bus.mdu_op[2];
        sgn_a       = is_div ? ~bus.mdu_op[0] : (bus.mdu_op[1:0] != 2'b11);
        sgn_b       = is_div ? ~bus.mdu_op[0] : ~bus.mdu_op[1];
        a_neg       = sgn_a & bus.in_a[XLEN-1];
        b_neg       = sgn_b & bus.in_b[XLEN-1];
        mag_a       = a_neg ? (~bus.in_a + ONE_X) : bus.in_a;
        mag_b       = b_neg ? (~bus.in_b + ONE_X) : bus.in_b;
        div_zero    = is_div && (bus.in_b == '0);
        div_ovf     = is_div && !bus.mdu_op[0] && (bus.in_a == MIN_NEG) && (bus.in_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = bus.mdu_op[1] ? bus.in_a : '1;
        end else if (div_ovf) begin
            special_res = bus.mdu_op[1] ? '0 : bus.in_a;
        end
    end

    // acc_q holds {hi, lo}: for multiply hi accumulates while lo shifts out the
    // multiplier; for divide hi is the partial remainder and lo turns into the quotient.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mag_b_q};
        div_next  = {div_trial[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0],
                     acc_q[XLEN-2:0], ~div_trial[XLEN]};
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s  = neg_q   ? (~acc_q + ONE_2X) : acc_q;
        quo_s   = neg_q   ? (~acc_q[XLEN-1:0] + ONE_X) : acc_q[XLEN-1:0];
        rem_s   = a_neg_q ? (~acc_q[2*XLEN-1:XLEN] + ONE_X) : acc_q[2*XLEN-1:XLEN];
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            a_neg_q     <= 1'b0;
            mag_b_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.mdu_op;
                        neg_q      <= a_neg ^ b_neg;
                        a_neg_q    <= a_neg;
                        mag_b_q    <= mag_b;
                        acc_q      <= {{XLEN{1'b0}}, mag_a};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (special) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_END) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomised checks of mul_div_unit with a result scoreboard,
// latency measurement, backpressure, flush and asynchronous reset.
module tb_mul_div_unit;
    localparam int XLEN = 32;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    mul_div_unit_if #(.XLEN(XLEN)) bus ();

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa;
        int          sb_v;
        sa   = $signed(a);
        sb_v = $signed(b);
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb_v); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb_v); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb_v;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb_v;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 2;
    endfunction

    // Present an operation and return just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        @(negedge clk);
        bus.mdu_op   = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.mdu_op   = 3'($urandom);
    endtask

    task automatic send(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.res = exp;
        e.lat = lat_of(op, a, b);
        sb.push_back(e);
        issue(op, a, b);
    endtask

    // Count edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic collect();
        int   lat;
        exp_t e;
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.out_valid || lat >= 200) break;
            @(posedge clk);
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "/result"}, bus.result, e.res);
            check({e.tag, "/zero"}, 32'(bus.zero), 32'(e.res == 32'd0));
            check({e.tag, "/latency"}, 32'(lat), 32'(e.lat));
            $display("op %s result %08h latency %0d", e.tag, bus.result, lat);
        end
    endtask

    task automatic finish_handshake(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "/in_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "/out_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        send(tag, op, a, b, exp);
        collect();
        finish_handshake(tag);
    endtask

    initial begin
        int          vcount;
        logic [31:0] held;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.in_valid  = 1'b0;
        bus.mdu_op    = 3'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/in_ready", 32'(bus.in_ready), 32'd1);
        check("reset/out_valid", 32'(bus.out_valid), 32'd0);
        check("reset/result", bus.result, 32'd0);
        check("reset/zero", 32'(bus.zero), 32'd1);

        run("MUL_7xm3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("MULH_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("MULHU_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("MULHSU_m1x2",  3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF);
        run("MUL_0x5",      3'd0, 32'd0,          32'd5,          32'd0);
        run("DIV_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD);
        run("REM_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF);
        run("DIVU_m7_2",    3'd5, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC);
        run("REMU_m7_2",    3'd7, 32'hFFFF_FFF9, 32'd2,          32'd1);
        run("DIVU_by0",     3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF);
        run("REM_by0",      3'd6, 32'd5,          32'd0,          32'd5);
        run("DIV_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("REM_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Backpressure: result held for 10 cycles with a second request waiting
        bus.out_ready = 1'b0;
        send("BP_DIVU_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
        collect();
        bus.mdu_op   = 3'd0;
        bus.in_a     = 32'd6;
        bus.in_b     = 32'd9;
        bus.in_valid = 1'b1;
        held = bus.result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp/result_stable", bus.result, 32'd14);
            check("bp/in_ready", 32'(bus.in_ready), 32'd0);
            check("bp/out_valid", 32'(bus.out_valid), 32'd1);
        end
        check("bp/result_held", bus.result, held);
        bus.out_ready = 1'b1;
        send("BP_second_MUL_6x9", 3'd0, 32'd6, 32'd9, 32'd54);
        collect();
        finish_handshake("BP_second");

        // Flush in the middle of CALC
        issue(3'd0, 32'd100, 32'd200);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush/in_ready", 32'(bus.in_ready), 32'd1);
        check("flush/out_valid", 32'(bus.out_valid), 32'd0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) vcount++;
        end
        check("flush/no_out_valid", 32'(vcount), 32'd0);

        // flush together with in_valid in IDLE must not accept
        @(negedge clk);
        flush        = 1'b1;
        bus.mdu_op   = 3'd0;
        bus.in_a     = 32'd2;
        bus.in_b     = 32'd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_idle/in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_idle/out_valid", 32'(bus.out_valid), 32'd0);

        run("MUL_3x4_after_flush", 3'd0, 32'd3, 32'd4, 32'd12);

        // Asynchronous reset in the middle of CALC
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst/in_ready", 32'(bus.in_ready), 32'd1);
        check("arst/out_valid", 32'(bus.out_valid), 32'd0);
        check("arst/result", bus.result, 32'd0);
        check("arst/zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised operations against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            if (i == 7) begin
                rop = 3'd4;
                ra  = 32'h8000_0000;
                rb  = 32'hFFFF_FFFF;
            end
            run($sformatf("RND%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the single-cycle ALU in the execute stage. Operands are accepted through a valid/ready handshake. The unit computes one bit per cycle over XLEN cycles and holds its result until the consumer takes it. It produces the same `result`/`zero` pair as the ALU, so the writeback mux treats both units identically.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.
- `CNT_W`, default $clog2(XLEN)+1: iteration counter width; derived, do not override.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  unit can accept an operation.
- `mdu_op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_a`  in  XLEN  rs1 operand.
- `in_b`  in  XLEN  rs2 operand.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result == 0`, combinational from the result register.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid`, latch the op, the operand signs and the operand magnitudes.
  - MULHSU treats `in_b` as unsigned. MULHU, DIVU and REMU treat both operands as unsigned.
  - Clear the counter and go to CALC.
  - Exception: the special cases below go directly to DONE.
- **CALC, multiply:** shift-add on magnitudes, producing a 2·XLEN-bit product.
- **CALC, divide:** restoring division on magnitudes, producing an XLEN-bit quotient and an XLEN-bit remainder.
- **CALC duration:** exactly XLEN cycles, then go to FIX.
- **FIX:**
  - Apply the sign.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Select the output: MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2·XLEN-1:XLEN]; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Load `result`, then go to DONE.
- **DONE:**
  - `out_valid` = 1 and `in_ready` = 0.
  - On `out_ready`, go to IDLE.
  - An accept cannot overlap the DONE cycle.
- **Special cases** (checked at accept; the result is loaded at the accept edge, no CALC or FIX):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give `in_a`.
  - Signed overflow (DIV/REM with `in_a` = 1 followed by XLEN-1 zeros and `in_b` = all-ones): DIV gives `in_a`; REM gives 0.
- **flush:**
  - Has priority over every transition; the next state is IDLE.
  - A pending or in-flight result is discarded and `out_valid` falls on the next edge.
  - `flush` and `in_valid` together in IDLE: no accept.
- **Inputs after accept:** `in_a`, `in_b` and `mdu_op` are don't-care.

## Timing
- **Reset values:** state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `zero` 1, counter 0, internal registers 0.
- **Reset mid-operation:** the in-flight op is lost; the unit is IDLE immediately.
- **Normal latency:** `out_valid` rises after the XLEN+2th rising edge following the accepting edge (1 edge into CALC, XLEN in CALC, 1 in FIX). For XLEN=32 this is 34 cycles.
- **Special-case latency:** `out_valid` is high in the cycle immediately after the accepting edge.
- **Backpressure:** `result` and `zero` are stable while `out_valid` = 1 and `out_ready` = 0, for any duration.
- **Throughput:** one operation per XLEN+3 cycles maximum.
- `in_ready` is a pure function of state (IDLE). It never depends combinationally on `in_valid`.
- `result` changes only on FIX exit, special-case accept, or reset.

## Test plan
- **MUL** 7 × 0xFFFFFFFD, `out_ready` held 1 → `result` 0xFFFFFFEB, `zero` 0, `out_valid` 34 edges after accept, `in_ready` 1 one cycle later.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - MUL 0 × 5 → 0 with `zero` 1.
- **Signed and unsigned divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 / 2 → 1.
- **Special cases:**
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
  - Each has `out_valid` 1 edge after accept.
- **Backpressure:** hold `out_ready` 0 for 10 cycles in DONE with a second `in_valid` asserted → `result` stable, `in_ready` 0, second op accepted only after the output handshake.
- **Abort paths:**
  - `flush` at CALC cycle 10 → `out_valid` never rises, `in_ready` 1 next cycle, and a fresh MUL 3 × 4 returns 12.
  - Deassert `rst_n` mid-CALC → all outputs at reset values immediately.
